hq2x_readout: RTL and testbench

- Downstream read sequencer for the 4-buffer hq2x output line store.
- Tracks which of the 4 line buffers hold completed 2x-wide output lines, in a small in-order queue.
- On each output-timing line start, streams one buffer out pixel-by-pixel at ce_pix rate, compensating for the store's 1-cycle registered read.
- Then hands the buffer back to the writer.

---
 rtl/hq2x_readout_if.sv | 32 +++
 rtl/hq2x_readout.sv | 93 +++++++++
 tb/tb_hq2x_readout.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hq2x_readout_if.sv
// hq2x_readout_if: bus between the hq2x output line store and its read sequencer
// slave  (sequencer): takes line_ready/line_ready_buf, line_start, ce_pix, q;
//                     drives rdaddr, rdbuf, pix_out, pix_valid, buf_release(_idx), pending, underrun, overflow
// master (environment): the mirror image
interface hq2x_readout_if #(
  parameter int LENGTH = 0,
  parameter int DWIDTH = 0
);
  localparam int AWIDTH = $clog2(2 * LENGTH) > 1 ? $clog2(2 * LENGTH) - 1 : 0;
  logic              line_ready;
  logic [1:0]        line_ready_buf;
  logic              line_start;
  logic              ce_pix;
  logic [AWIDTH:0]   rdaddr;
  logic [1:0]        rdbuf;
  logic [DWIDTH:0]   q;
  logic [DWIDTH:0]   pix_out;
  logic              pix_valid;
  logic              buf_release;
  logic [1:0]        buf_release_idx;
  logic [2:0]        pending;
  logic              underrun;
  logic              overflow;
  modport slave (
    input  line_ready, line_ready_buf, line_start, ce_pix, q,
    output rdaddr, rdbuf, pix_out, pix_valid, buf_release, buf_release_idx, pending, underrun, overflow
  );
  modport master (
    output line_ready, line_ready_buf, line_start, ce_pix, q,
    input  rdaddr, rdbuf, pix_out, pix_valid, buf_release, buf_release_idx, pending, underrun, overflow
  );
endinterface

// File: rtl/hq2x_readout.sv
// hq2x_readout: queues finished line buffers and streams one out per output line start
// clk, reset (async, active-high) plus the hq2x_readout_if slave port s:
//   line_ready/line_ready_buf push a finished buffer, line_start starts a line, ce_pix paces pixels,
//   rdaddr/rdbuf address the store whose q returns 1 clk later as pix_out/pix_valid,
//   buf_release/buf_release_idx hand a buffer back, pending/underrun/overflow report queue status
module hq2x_readout #(
  parameter int LENGTH = 0,
  parameter int DWIDTH = 0
) (
  input logic clk,
  input logic reset,
  hq2x_readout_if.slave s
);
  localparam int AWIDTH = $clog2(2 * LENGTH) > 1 ? $clog2(2 * LENGTH) - 1 : 0;
  localparam logic [AWIDTH:0] LAST = (AWIDTH + 1)'(2 * LENGTH - 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, BLANK} state_e;
  state_e state_q, state_d;
  logic [1:0] fifo_q [4];
  logic [1:0] wp_q, rp_q, rdbuf_q, rdbuf_d, rel_idx_q, rel_idx_d;
  logic [2:0] cnt_q;
  logic [AWIDTH:0] pcnt_q, pcnt_d;
  logic [DWIDTH:0] pix_q, pix_d, pix_now;
  logic issue_q, issue_d, act_q, act_d, rel_q, rel_d, und_q, und_d, ovf_q, ovf_d;
  logic full, empty, push, start, pop, accept, last;
  assign full   = cnt_q[2];
  assign empty  = cnt_q == 3'd0;
  assign push   = s.line_ready & ~full;
  assign start  = state_q == IDLE & s.line_start;
  assign pop    = start & ~empty;
  assign accept = s.ce_pix & (state_q == ACTIVE | state_q == BLANK);
  assign last   = accept & pcnt_q == LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = start ? (empty ? BLANK : ACTIVE) :
              last ? (state_q == ACTIVE ? DRAIN : IDLE) :
              state_q == DRAIN ? IDLE : state_q;
  end
  always_comb begin
    pcnt_d    = start ? '0 : accept ? pcnt_q + (AWIDTH + 1)'(1) : pcnt_q;
    rdbuf_d   = pop ? fifo_q[rp_q] : rdbuf_q;
    issue_d   = accept;
    act_d     = state_q == ACTIVE;
    pix_now   = act_q ? s.q : '0;
    pix_d     = issue_q ? pix_now : pix_q;
    rel_d     = state_q == DRAIN;
    rel_idx_d = state_q == DRAIN ? rdbuf_q : rel_idx_q;
    und_d     = und_q | (start & empty);
    ovf_d     = ovf_q | (s.line_ready & full);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      pcnt_q <= '0;
      rdbuf_q <= '0;
      issue_q <= 1'b0;
      act_q <= 1'b0;
      pix_q <= '0;
      rel_q <= 1'b0;
      rel_idx_q <= '0;
      und_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (push) fifo_q[wp_q] <= s.line_ready_buf;
      wp_q <= wp_q + {1'b0, push};
      rp_q <= rp_q + {1'b0, pop};
      cnt_q <= cnt_q + {2'b0, push} - {2'b0, pop};
      pcnt_q <= pcnt_d;
      rdbuf_q <= rdbuf_d;
      issue_q <= issue_d;
      act_q <= act_d;
      pix_q <= pix_d;
      rel_q <= rel_d;
      rel_idx_q <= rel_idx_d;
      und_q <= und_d;
      ovf_q <= ovf_d;
    end
  end
  // the store's registered read lands on q exactly when issue_q is high, so q passes straight through
  assign s.pix_out         = pix_d;
  assign s.pix_valid       = issue_q;
  assign s.rdaddr          = pcnt_q;
  assign s.rdbuf           = rdbuf_q;
  assign s.buf_release     = rel_q;
  assign s.buf_release_idx = rel_idx_q;
  assign s.pending         = cnt_q;
  assign s.underrun        = und_q;
  assign s.overflow        = ovf_q;
endmodule

// File: tb/tb_hq2x_readout.sv
// tb_hq2x_readout: table, hand-written and random line playback against a queue-level model
module tb_hq2x_readout;
  localparam int LENGTH = 4;
  localparam int NPIX = 2 * LENGTH;
  logic clk = 1'b0;
  logic reset = 1'b1;
  hq2x_readout_if #(.LENGTH(LENGTH), .DWIDTH(7)) bus();
  hq2x_readout #(.LENGTH(LENGTH), .DWIDTH(7)) dut (.clk(clk), .reset(reset), .s(bus));
  always #5 clk = ~clk;
  logic [7:0] mem [4][NPIX];
  always @(posedge clk) bus.q <= mem[bus.rdbuf][bus.rdaddr];
  int passed = 0;
  int total = 0;
  logic [7:0] last_p = '0;
  int mq[$];
  bit movf, mund;
  typedef struct {
    int pre;
    int ws;
    int per;
    int exp_buf;
    int exp_pend;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " rdaddr"}, 32'(bus.rdaddr), 0);
    chk({tag, " rdbuf"}, 32'(bus.rdbuf), 0);
    chk({tag, " pix_out"}, 32'(bus.pix_out), 0);
    chk({tag, " pix_valid"}, 32'(bus.pix_valid), 0);
    chk({tag, " buf_release"}, 32'(bus.buf_release), 0);
    chk({tag, " buf_release_idx"}, 32'(bus.buf_release_idx), 0);
    chk({tag, " pending"}, 32'(bus.pending), 0);
    chk({tag, " underrun"}, 32'(bus.underrun), 0);
    chk({tag, " overflow"}, 32'(bus.overflow), 0);
  endtask
  task automatic ready(input int b);
    bus.line_ready = 1'b1;
    bus.line_ready_buf = 2'(b);
    @(posedge clk); #1;
    bus.line_ready = 1'b0;
  endtask
  // one output line: start (optionally with a simultaneous line_ready), pace ce_pix every per clks,
  // and check every cycle against the expected pixel stream of buffer exp_buf (-1 = blank line)
  task automatic play_line(input int per, input int ws, input int exp_buf, input int exp_pend);
    int n = 0;
    int rel_at = -1;
    bit exp_v = 1'b0;
    bit ce;
    logic [7:0] exp_p = '0;
    bus.line_start = 1'b1;
    if (ws >= 0) begin
      bus.line_ready = 1'b1;
      bus.line_ready_buf = 2'(ws);
    end
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    bus.line_ready = 1'b0;
    for (int k = 0; k < NPIX * per + 4; k++) begin
      ce = (k % per) == 0;
      bus.ce_pix = ce;
      @(negedge clk);
      chk("pix_valid", 32'(bus.pix_valid), 32'(exp_v));
      chk("pix_out", 32'(bus.pix_out), 32'(exp_v ? exp_p : last_p));
      if (exp_v) last_p = exp_p;
      chk("buf_release", 32'(bus.buf_release), 32'(k == rel_at));
      if (k == rel_at) chk("buf_release_idx", 32'(bus.buf_release_idx), 32'(exp_buf));
      if (k == 0) chk("pending", 32'(bus.pending), 32'(exp_pend));
      if (ce && n < NPIX) begin
        if (exp_buf >= 0) begin
          chk("rdaddr", 32'(bus.rdaddr), 32'(n));
          chk("rdbuf", 32'(bus.rdbuf), 32'(exp_buf));
        end
        exp_p = exp_buf >= 0 ? mem[exp_buf][n] : 8'h00;
        n++;
        if (n == NPIX && exp_buf >= 0) rel_at = k + 2;
        exp_v = 1'b1;
      end else exp_v = 1'b0;
      @(posedge clk); #1;
    end
    bus.ce_pix = 1'b0;
  endtask
  initial begin
    int eb, ws, per;
    bit full_before;
    bus.line_ready = 1'b0;
    bus.line_ready_buf = '0;
    bus.line_start = 1'b0;
    bus.ce_pix = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < NPIX; a++) mem[b][a] = 8'($urandom);
    #2;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tbl[0] = '{pre: 2, ws: -1, per: 1, exp_buf: 2, exp_pend: 0};
    tbl[1] = '{pre: 1, ws: -1, per: 3, exp_buf: 1, exp_pend: 0};
    tbl[2] = '{pre: -1, ws: -1, per: 1, exp_buf: -1, exp_pend: 0};
    tbl[3] = '{pre: 3, ws: -1, per: 2, exp_buf: 3, exp_pend: 0};
    tbl[4] = '{pre: 0, ws: 1, per: 1, exp_buf: 0, exp_pend: 1};
    tbl[5] = '{pre: -1, ws: -1, per: 1, exp_buf: 1, exp_pend: 0};
    tbl[6] = '{pre: -1, ws: 2, per: 2, exp_buf: -1, exp_pend: 1};
    tbl[7] = '{pre: -1, ws: -1, per: 1, exp_buf: 2, exp_pend: 0};
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pre >= 0) begin
        ready(tbl[i].pre);
        chk("pending after ready", 32'(bus.pending), 1);
      end
      play_line(tbl[i].per, tbl[i].ws, tbl[i].exp_buf, tbl[i].exp_pend);
    end
    chk("underrun sticky", 32'(bus.underrun), 1);
    chk("overflow clear", 32'(bus.overflow), 0);
    for (int b = 0; b < 5; b++) ready(b % 4);
    chk("pending full", 32'(bus.pending), 4);
    chk("overflow set", 32'(bus.overflow), 1);
    for (int b = 0; b < 4; b++) play_line(1, -1, b, 3 - b);
    chk("pending drained", 32'(bus.pending), 0);
    ready(2);
    bus.line_start = 1'b1;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    bus.ce_pix = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_zero("midline reset");
    bus.ce_pix = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("release during reset", 32'(bus.buf_release), 0);
    end
    @(posedge clk); #1 reset = 1'b0;
    last_p = '0;
    ready(1);
    play_line(1, -1, 1, 0);
    mq.delete();
    movf = 1'b0;
    mund = 1'b0;
    for (int it = 0; it < 20; it++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        eb = $urandom_range(0, 3);
        ready(eb);
        if (mq.size() < 4) mq.push_back(eb);
        else movf = 1'b1;
      end
      ws = $urandom_range(0, 2) == 0 ? $urandom_range(0, 3) : -1;
      full_before = mq.size() == 4;
      if (mq.size() != 0) eb = mq.pop_front();
      else begin
        eb = -1;
        mund = 1'b1;
      end
      if (ws >= 0) begin
        if (full_before) movf = 1'b1;
        else mq.push_back(ws);
      end
      per = $urandom_range(1, 3);
      play_line(per, ws, eb, mq.size());
    end
    chk("random underrun", 32'(bus.underrun), 32'(mund));
    chk("random overflow", 32'(bus.overflow), 32'(movf));
    chk("random pending", 32'(bus.pending), 32'(mq.size()));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
